// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-client round-robin sequencer for a single-port RAM
// Serialises client read/write commands onto one RAM port with a one-cycle ack.
module ram_port_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              gnt_id,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic                ptr_q, ptr_d;
  logic                gnt_q, gnt_d;
  logic                cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                win;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      gnt_q       <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // With both clients requesting, the pointer decides; otherwise the lone requester wins.
  always_comb begin
    win = (req0 && req1) ? ptr_q : req1;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt_d       = win;
          ptr_d       = ~win;
          cmd_we_d    = win ? we1 : we0;
          cmd_addr_d  = win ? addr1 : addr0;
          cmd_wdata_d = win ? wdata1 : wdata0;
          state_d     = ACCESS;
        end
      end
      ACCESS:  state_d = cmd_we_q ? DONE : RDWAIT;
      RDWAIT: begin
        rdata_d = mem_rdata;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack0      = 1'b0;
    ack1      = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = (state_q != IDLE);
    gnt_id    = gnt_q;
    rdata     = rdata_q;
    case (state_q)
      ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = cmd_we_q;
        mem_addr  = cmd_addr_q;
        mem_wdata = cmd_wdata_q;
      end
      DONE: begin
        ack0 = ~gnt_q;
        ack1 = gnt_q;
      end
      default: ;
    endcase
  end

endmodule
